rom_header_reader: RTL and testbench

- Active post-load SNES header probe. On a start pulse it issues 16-bit word reads to the cartridge memory port (SDRAM arbiter side) at the LoROM, HiROM and ExHiROM header windows.
- It scores each candidate header and reports the map type: 0=LoROM, 1=HiROM, 2=ExHiROM.
- It is the initiator/reader counterpart of the download-stream sniffer. It runs after the loader has finished writing the ROM, for example on a save-state reload, where no download stream is available.

---
 rtl/rom_header_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_rom_header_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_header_reader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_header_reader
//  Description : Post-load SNES header probe. On a start pulse, reads the
//                LoROM / HiROM / ExHiROM header windows through a 16-bit read
//                port, scores each candidate and reports the map type
//                (0=LoROM, 1=HiROM, 2=ExHiROM).
//                Optional feature macro: READ_TIMEOUT_EN (ack watchdog).
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_header_reader #(
  parameter int ADDR_W         = 25,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk_74a,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       rom_file_size,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [15:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        parsed_rom_type,
  output logic [7:0]        lorom_score,
  output logic [7:0]        hirom_score,
  output logic [7:0]        exhirom_score
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_SCORE  = 3'd3,
    S_DECIDE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cand;
  logic [2:0]        r_word;
  logic [31:0]       r_size;
  logic              r_off;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_done;
  logic [2:0]        r_type;
  logic [7:0]        r_lo, r_hi, r_ex;
  logic [7:0]        r_map, r_htype, r_hsize, r_sram, r_region, r_devid;
  logic [15:0]       r_cmpl, r_csum;

  logic              w_timeout;
  logic [31:0]       w_size_src;
  logic              w_off_src;
  logic [2:0]        w_from;
  logic              w_pick_ok;
  logic [1:0]        w_pick_cand;
  logic [15:0]       w_sum;
  logic [7:0]        w_sub;
  logic [7:0]        w_score;

  // Header window base address for a candidate, shifted past a copier header.
  function automatic logic [31:0] f_base(input logic [1:0] cand, input logic off);
    logic [31:0] b;
    case (cand)
      2'd0:    b = 32'h0000_7FD4;
      2'd1:    b = 32'h0000_FFD4;
      default: b = 32'h0040_FFD4;
    endcase
    return b + (off ? 32'h0000_0200 : 32'h0000_0000);
  endfunction

  // Pick the next candidate whose header window lies inside the file; windows
  // that do not fit are skipped without spending any cycles.
  always_comb begin
    w_size_src  = (r_state == S_IDLE) ? rom_file_size    : r_size;
    w_off_src   = (r_state == S_IDLE) ? rom_file_size[9] : r_off;
    w_from      = (r_state == S_IDLE) ? 3'd0 : ({1'b0, r_cand} + 3'd1);
    w_pick_ok   = 1'b0;
    w_pick_cand = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if ((3'(i) >= w_from) &&
          ((f_base(2'(i), w_off_src) + 32'h0000_000C) <= w_size_src)) begin
        w_pick_ok   = 1'b1;
        w_pick_cand = 2'(i);
      end
    end
  end

  // Score the fields captured for the current candidate.
  always_comb begin
    w_sum = r_csum + r_cmpl;
    w_sub = 8'd0;
    if ((r_csum != 16'h0) && (r_cmpl != 16'h0) && (w_sum == 16'hFFFF)) w_sub = w_sub + 8'd4;
    if (r_devid == 8'h33) w_sub = w_sub + 8'd2;
    if (r_htype  < 8'd8)  w_sub = w_sub + 8'd1;
    if (r_hsize  < 8'd16) w_sub = w_sub + 8'd1;
    if (r_sram   < 8'd8)  w_sub = w_sub + 8'd1;
    if (r_region < 8'd14) w_sub = w_sub + 8'd1;
    case (r_cand)
      2'd0:    if ((r_map == 8'h20) || (r_map == 8'h22)) w_sub = w_sub + 8'd2;
      2'd1:    if (r_map == 8'h21) w_sub = w_sub + 8'd2;
      default: if ((r_map == 8'h25) || (r_map == 8'h35)) w_sub = w_sub + 8'd2;
    endcase
    w_score = w_sub;
    if ((r_cand == 2'd2) && (w_sub != 8'd0)) w_score = w_sub + 8'd4;
  end

`ifdef READ_TIMEOUT_EN
  logic [9:0] r_to_cnt;

  // Ack watchdog: restarts on every request, counts while waiting.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= 10'd0;
    end else if (r_state == S_REQ) begin
      r_to_cnt <= 10'd0;
    end else if ((r_state == S_WAIT) && !rd_ack) begin
      r_to_cnt <= r_to_cnt + 10'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !rd_ack && (r_to_cnt == 10'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = w_pick_ok ? S_REQ : S_DECIDE;
      S_REQ:    w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (rd_ack)         w_state_nxt = (r_word == 3'd5) ? S_SCORE : S_REQ;
        else if (w_timeout) w_state_nxt = w_pick_ok ? S_REQ : S_DECIDE;
      end
      S_SCORE:  w_state_nxt = w_pick_ok ? S_REQ : S_DECIDE;
      S_DECIDE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: read port, field capture, per-candidate scores and the verdict.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_cand    <= 2'd0;
      r_word    <= 3'd0;
      r_size    <= 32'd0;
      r_off     <= 1'b0;
      r_rd_req  <= 1'b0;
      r_rd_addr <= '0;
      r_done    <= 1'b0;
      r_type    <= 3'd0;
      r_lo      <= 8'd0;
      r_hi      <= 8'd0;
      r_ex      <= 8'd0;
      r_map     <= 8'd0;
      r_htype   <= 8'd0;
      r_hsize   <= 8'd0;
      r_sram    <= 8'd0;
      r_region  <= 8'd0;
      r_devid   <= 8'd0;
      r_cmpl    <= 16'd0;
      r_csum    <= 16'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_size <= rom_file_size;
            r_off  <= rom_file_size[9];
            r_cand <= w_pick_cand;
            r_word <= 3'd0;
            r_lo   <= 8'd0;
            r_hi   <= 8'd0;
            r_ex   <= 8'd0;
          end
        end
        S_REQ: begin
          r_rd_req  <= 1'b1;
          r_rd_addr <= ADDR_W'(f_base(r_cand, r_off) + {28'd0, r_word, 1'b0});
        end
        S_WAIT: begin
          if (rd_ack) begin
            r_rd_req <= 1'b0;
            case (r_word)
              3'd0: r_map <= rd_data[15:8];
              3'd1: begin r_htype <= rd_data[7:0]; r_hsize  <= rd_data[15:8]; end
              3'd2: begin r_sram  <= rd_data[7:0]; r_region <= rd_data[15:8]; end
              3'd3: r_devid <= rd_data[7:0];
              3'd4: r_cmpl  <= rd_data;
              default: r_csum <= rd_data;
            endcase
            if (r_word != 3'd5) r_word <= r_word + 3'd1;
          end else if (w_timeout) begin
            // Abandoned candidate keeps the zero score it was cleared to.
            r_rd_req <= 1'b0;
            r_cand   <= w_pick_cand;
            r_word   <= 3'd0;
          end
        end
        S_SCORE: begin
          case (r_cand)
            2'd0:    r_lo <= w_score;
            2'd1:    r_hi <= w_score;
            default: r_ex <= w_score;
          endcase
          r_cand <= w_pick_cand;
          r_word <= 3'd0;
        end
        S_DECIDE: begin
          if ((r_lo >= r_hi) && (r_lo >= r_ex)) r_type <= 3'd0;
          else if (r_hi >= r_ex)                r_type <= 3'd1;
          else if (r_ex != 8'd0)                r_type <= 3'd2;
          else                                  r_type <= 3'd0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_req          = r_rd_req;
  assign rd_addr         = r_rd_addr;
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;
  assign parsed_rom_type = r_type;
  assign lorom_score     = r_lo;
  assign hirom_score     = r_hi;
  assign exhirom_score   = r_ex;

endmodule
`default_nettype wire

// File: tb/tb_rom_header_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_header_reader
//  Description : Directed, table-driven bench for rom_header_reader with a
//                byte-addressed memory model answering the read port.
//                Optional feature macro: READ_TIMEOUT_EN (watchdog sequence).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_header_reader;
  localparam int ADDR_W = 25;

  logic              clk_74a = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       rom_file_size = 32'd0;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack = 1'b0;
  logic [15:0]       rd_data = 16'd0;
  logic              busy, done;
  logic [2:0]        parsed_rom_type;
  logic [7:0]        lorom_score, hirom_score, exhirom_score;

  rom_header_reader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(1023)) dut (
    .clk_74a(clk_74a), .reset_n(reset_n), .start(start), .rom_file_size(rom_file_size),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .busy(busy), .done(done), .parsed_rom_type(parsed_rom_type),
    .lorom_score(lorom_score), .hirom_score(hirom_score), .exhirom_score(exhirom_score)
  );

  always #5 clk_74a = ~clk_74a;

  typedef struct {
    string       nm;
    logic [31:0] fsize;
    int          hcand;      // window holding a header, -1 = none
    logic [7:0]  map, typ, sz, sram, region, devid;
    logic [15:0] cmpl, csum;
    int          max_wait;
    logic [7:0]  e_lo, e_hi, e_ex;
    logic [2:0]  e_type;
    int          e_reqs;
    int          e_lat;      // -1 = not checked
    logic [31:0] watch;
    logic        e_seen;
  } vec_t;

  vec_t vecs[9];

  // Memory image; unwritten bytes read back as 0xFF.
  logic [7:0] mem [int];
  int max_wait, wait_left, n_reqs, stable_err, drop_cnt, hold, max_hold;
  int noack_lo, noack_hi;
  logic in_req, seen;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] watch;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] rd_byte(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'hFF;
  endfunction

  function automatic int base_of(input int c, input logic [31:0] fs);
    int b;
    b = (c == 0) ? 32'h7FD4 : (c == 1) ? 32'hFFD4 : 32'h40FFD4;
    if (fs[9]) b = b + 32'h200;
    return b;
  endfunction

  task automatic put_header(input vec_t v);
    int b;
    b = base_of(v.hcand, v.fsize);
    mem[b + 1]  = v.map;
    mem[b + 2]  = v.typ;
    mem[b + 3]  = v.sz;
    mem[b + 4]  = v.sram;
    mem[b + 5]  = v.region;
    mem[b + 6]  = v.devid;
    mem[b + 8]  = v.cmpl[7:0];
    mem[b + 9]  = v.cmpl[15:8];
    mem[b + 10] = v.csum[7:0];
    mem[b + 11] = v.csum[15:8];
  endtask

  task automatic setup_mem(input vec_t v);
    mem.delete();
    if (v.hcand >= 0) put_header(v);
    max_wait   = v.max_wait;
    wait_left  = $urandom_range(v.max_wait, 0);
    n_reqs     = 0;
    stable_err = 0;
    drop_cnt   = 0;
    max_hold   = 0;
    seen       = 1'b0;
    watch      = v.watch;
    noack_lo   = 0;
    noack_hi   = 0;
    rom_file_size = v.fsize;
  endtask

  // Memory responder: acks with a per-request random delay, tracks request
  // stability, request count, and requests withdrawn without an ack.
  initial begin
    in_req = 1'b0;
    hold   = 0;
    forever begin
      @(negedge clk_74a);
      if (!reset_n) begin
        rd_ack = 1'b0;
        in_req = 1'b0;
      end else if (rd_ack) begin
        rd_ack = 1'b0;
      end else if (rd_req) begin
        if (!in_req) begin
          in_req   = 1'b1;
          req_addr = rd_addr;
          hold     = 0;
        end else if (rd_addr !== req_addr) begin
          stable_err++;
        end
        hold++;
        if (hold > max_hold) max_hold = hold;
        if ((int'(rd_addr) >= noack_lo) && (int'(rd_addr) < noack_hi)) begin
          // never answered
        end else if (wait_left == 0) begin
          rd_ack  = 1'b1;
          rd_data = {rd_byte(int'(rd_addr) + 1), rd_byte(int'(rd_addr))};
          n_reqs++;
          if (32'(rd_addr) == watch) seen = 1'b1;
          in_req    = 1'b0;
          wait_left = $urandom_range(max_wait, 0);
        end else begin
          wait_left--;
        end
      end else if (in_req) begin
        drop_cnt++;
        in_req = 1'b0;
      end
    end
  end

  // Pulse start and count posedges until done; optional extra start pulse.
  task automatic probe(input int restart_at, output int lat, output logic busy_early);
    @(negedge clk_74a);
    start = 1'b1;
    lat = 0;
    busy_early = 1'b0;
    while (1) begin
      @(posedge clk_74a);
      #1;
      lat++;
      start = (lat == restart_at);
      if (lat == 1) busy_early = busy;
      if (done || lat >= 20000) break;
    end
    start = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input int lat, input logic busy_early);
    chk({v.nm, ".done_seen"}, 32'(done), 32'd1);
    chk({v.nm, ".lo"},   32'(lorom_score),     32'(v.e_lo));
    chk({v.nm, ".hi"},   32'(hirom_score),     32'(v.e_hi));
    chk({v.nm, ".ex"},   32'(exhirom_score),   32'(v.e_ex));
    chk({v.nm, ".type"}, 32'(parsed_rom_type), 32'(v.e_type));
    chk({v.nm, ".reqs"}, 32'(n_reqs),          32'(v.e_reqs));
    chk({v.nm, ".addr_seen"}, 32'(seen),       32'(v.e_seen));
    chk({v.nm, ".addr_stable_errs"}, 32'(stable_err), 32'd0);
    chk({v.nm, ".req_dropped_early"}, 32'(drop_cnt),  32'd0);
    chk({v.nm, ".busy_during"}, 32'(busy_early), 32'd1);
    chk({v.nm, ".busy_at_done"}, 32'(busy), 32'd0);
    if (v.e_lat > 0) chk({v.nm, ".latency"}, 32'(lat), 32'(v.e_lat));
    @(posedge clk_74a);
    #1;
    chk({v.nm, ".done_one_cycle"}, 32'(done), 32'd0);
    chk({v.nm, ".type_held"}, 32'(parsed_rom_type), 32'(v.e_type));
  endtask

  initial begin
    int lat;
    logic be, found;
    vec_t tv;

    // Latency with zero-wait ack is 13 cycles per read window plus 2; windows
    // outside the file cost nothing. Three windows -> 41.
    //          name                fsize        hc  map    typ    sz     sram   reg    devid  cmpl      csum      wt  lo     hi     ex     ty    rq  lat  watch        seen
    vecs[0] = '{"lorom",            32'h100000,  0,  8'h20, 8'h02, 8'h0A, 8'h03, 8'h01, 8'h33, 16'hEDCB, 16'h1234, 0, 8'd12, 8'd0,  8'd0,  3'd0, 12, 28, 32'h7FD4,    1'b1};
    vecs[1] = '{"hirom_copier",     32'h100200,  1,  8'h21, 8'h01, 8'h0B, 8'h00, 8'h00, 8'h33, 16'h5555, 16'hAAAA, 0, 8'd0,  8'd12, 8'd0,  3'd1, 12, 28, 32'h101D4,   1'b1};
    vecs[2] = '{"exhirom",          32'h600000,  2,  8'h25, 8'h02, 8'h0C, 8'h05, 8'h0D, 8'h00, 16'h0F0F, 16'hF0F0, 0, 8'd0,  8'd0,  8'd14, 3'd2, 18, 41, 32'h40FFD4,  1'b1};
    vecs[3] = '{"exhirom_rndwait",  32'h600000,  2,  8'h25, 8'h02, 8'h0C, 8'h05, 8'h0D, 8'h00, 16'h0F0F, 16'hF0F0, 7, 8'd0,  8'd0,  8'd14, 3'd2, 18, -1, 32'h40FFDE,  1'b1};
    vecs[4] = '{"c1_just_fits",     32'h10000,   1,  8'h21, 8'h00, 8'h0F, 8'h07, 8'h0D, 8'h00, 16'h8000, 16'h7FFF, 0, 8'd0,  8'd10, 8'd0,  3'd1, 12, 28, 32'hFFDE,    1'b1};
    vecs[5] = '{"c1_too_small",     32'hFDFF,    1,  8'h21, 8'h00, 8'h0F, 8'h07, 8'h0D, 8'h00, 16'h8000, 16'h7FFF, 0, 8'd0,  8'd0,  8'd0,  3'd0, 6,  15, 32'hFFD4,    1'b0};
    vecs[6] = '{"csum_zero",        32'h80000,   0,  8'h22, 8'h02, 8'h0A, 8'h03, 8'h01, 8'h33, 16'hFFFF, 16'h0000, 0, 8'd8,  8'd0,  8'd0,  3'd0, 12, 28, 32'hFFD4,    1'b1};
    vecs[7] = '{"all_skipped",      32'h100,    -1,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 0, 8'd0,  8'd0,  8'd0,  3'd0, 0,  2,  32'h7FD4,    1'b0};
    vecs[8] = '{"ex_field_limits",  32'h600000,  2,  8'h35, 8'h08, 8'h10, 8'h08, 8'h0E, 8'h00, 16'h1111, 16'hEEEE, 0, 8'd0,  8'd0,  8'd10, 3'd2, 18, 41, 32'h40FFDE,  1'b1};

    // Reset state
    repeat (3) @(posedge clk_74a);
    #1;
    chk("reset.rd_req",  32'(rd_req),  32'd0);
    chk("reset.rd_addr", 32'(rd_addr), 32'd0);
    chk("reset.busy",    32'(busy),    32'd0);
    chk("reset.done",    32'(done),    32'd0);
    chk("reset.type",    32'(parsed_rom_type), 32'd0);
    chk("reset.scores",  {8'd0, lorom_score, hirom_score, exhirom_score}, 32'd0);
    @(negedge clk_74a);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_74a);

    for (int i = 0; i < 9; i++) begin
      setup_mem(vecs[i]);
      probe(-1, lat, be);
      check_vec(vecs[i], lat, be);
    end

    // Reset during the second window's reads aborts at once.
    setup_mem(vecs[2]);
    @(negedge clk_74a);
    start = 1'b1;
    @(posedge clk_74a);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk_74a);
      #1;
      if (rd_req && (rd_addr == 25'h0FFD6)) found = 1'b1;
    end
    chk("rst_mid.reached_c1", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.rd_req",  32'(rd_req),  32'd0);
    chk("rst_mid.busy",    32'(busy),    32'd0);
    chk("rst_mid.rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_mid.type",    32'(parsed_rom_type), 32'd0);
    chk("rst_mid.done",    32'(done),    32'd0);
    repeat (2) @(posedge clk_74a);
    @(negedge clk_74a);
    #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk_74a);

    // Clean rerun with a start pulse injected while busy.
    tv = vecs[2];
    tv.nm = "rerun_start_in_busy";
    setup_mem(tv);
    probe(10, lat, be);
    check_vec(tv, lat, be);

`ifdef READ_TIMEOUT_EN
    // Second window never answers: watchdog abandons it and the probe ends.
    tv = vecs[0];
    setup_mem(tv);
    tv.hcand = 1;
    tv.map   = 8'h21;
    put_header(tv);
    noack_lo = 32'hFFD4;
    noack_hi = 32'hFFE0;
    probe(-1, lat, be);
    chk("timeout.done_seen", 32'(done), 32'd1);
    chk("timeout.lo",   32'(lorom_score),     32'd12);
    chk("timeout.hi",   32'(hirom_score),     32'd0);
    chk("timeout.type", 32'(parsed_rom_type), 32'd0);
    chk("timeout.acks", 32'(n_reqs),          32'd6);
    chk("timeout.drops", 32'(drop_cnt),       32'd1);
    chk("timeout.hold_in_range", 32'((max_hold >= 1023) && (max_hold <= 1026)), 32'd1);
    noack_lo = 0;
    noack_hi = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
